// File: rtl/i_axi_rd_bridge.sv
// Instruction-side bridge: sram-like fetch requests to a single-outstanding,
// single-beat AXI4 read master (AR/R channels only).
module i_axi_rd_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        rd_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state;
    logic [1:0] size_q;
    logic       beat_ours;

    // Write data and rlast carry no meaning for a single-beat read-only port.
    logic unused_inputs;
    assign unused_inputs = ^{inst_wdata, rlast};

    // Handshake outputs decode straight from state, so an async reset drops
    // arvalid/rready/data_ok in the same cycle it is asserted.
    assign inst_addr_ok = (state == S_IDLE) && inst_req && !inst_wr;
    assign arvalid      = (state == S_AR);
    assign rready       = (state == S_R);
    assign inst_data_ok = (state == S_DONE);

    assign arid    = ARID_VAL;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign beat_ours = rvalid && (rid == ARID_VAL);

    // NOTE: all state below uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            araddr     <= 32'd0;
            size_q     <= 2'd0;
            inst_rdata <= 32'd0;
            rd_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst_addr_ok) begin
                        araddr <= inst_addr;
                        size_q <= inst_size;
                        state  <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) state <= S_R;
                end
                S_R: begin
                    // Beats with a foreign id are acked by rready and dropped.
                    if (beat_ours) begin
                        inst_rdata <= rdata;
                        if (rresp != 2'b00) rd_err <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i_axi_rd_bridge.sv
// Directed bench for i_axi_rd_bridge: cycle-by-cycle AXI slave stimulus with
// hand-computed expectations.
module tb_i_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rd_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i_axi_rd_bridge #(.ARID_VAL(4'd0)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .rd_err(rd_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [1:0] size,
                            input int ar_wait, input bit stray,
                            input logic [31:0] data, input logic [1:0] resp,
                            input bit exp_err, input bit hold_req);
        inst_req  = 1'b1;
        inst_wr   = 1'b0;
        inst_addr = addr;
        inst_size = size;
        #1;
        check("addr_ok_idle", 32'(inst_addr_ok), 32'd1);
        check("data_ok_idle", 32'(inst_data_ok), 32'd0);
        check("arvalid_idle", 32'(arvalid), 32'd0);
        step();
        inst_req  = hold_req;
        inst_addr = 32'hFFFF_FFF0;
        inst_size = 2'd0;
        arready   = 1'b0;
        for (int i = 0; i < ar_wait; i++) begin
            #1;
            check("arvalid_wait", 32'(arvalid), 32'd1);
            check("araddr_wait", araddr, addr);
            check("addr_ok_ar", 32'(inst_addr_ok), 32'd0);
            step();
        end
        arready = 1'b1;
        #1;
        check("arvalid", 32'(arvalid), 32'd1);
        check("araddr", araddr, addr);
        check("arsize", 32'(arsize), {29'd0, 1'b0, size});
        check("arlen", 32'(arlen), 32'd0);
        check("arburst", 32'(arburst), 32'd1);
        check("arid", 32'(arid), 32'd0);
        check("addr_ok_ar", 32'(inst_addr_ok), 32'd0);
        step();
        arready = 1'b0;
        if (stray) begin
            rvalid = 1'b1;
            rid    = 4'd3;
            rdata  = 32'hDEAD_BEEF;
            rresp  = 2'b00;
            #1;
            check("rready_stray", 32'(rready), 32'd1);
            check("data_ok_stray", 32'(inst_data_ok), 32'd0);
            step();
        end
        rvalid = 1'b1;
        rid    = 4'd0;
        rdata  = data;
        rresp  = resp;
        rlast  = 1'b1;
        #1;
        check("rready", 32'(rready), 32'd1);
        check("arvalid_r", 32'(arvalid), 32'd0);
        check("data_ok_r", 32'(inst_data_ok), 32'd0);
        check("addr_ok_r", 32'(inst_addr_ok), 32'd0);
        step();
        rvalid = 1'b0;
        rid    = 4'd0;
        rdata  = 32'h0;
        rresp  = 2'b00;
        rlast  = 1'b0;
        #1;
        check("data_ok", 32'(inst_data_ok), 32'd1);
        check("rdata", inst_rdata, data);
        check("rd_err", 32'(rd_err), 32'(exp_err));
        check("addr_ok_done", 32'(inst_addr_ok), 32'd0);
        check("rready_done", 32'(rready), 32'd0);
        step();
        #1;
        check("data_ok_drop", 32'(inst_data_ok), 32'd0);
        check("rdata_hold", inst_rdata, data);
        check("addr_ok_after", 32'(inst_addr_ok), 32'(hold_req));
    endtask

    initial begin
        rst        = 1'b1;
        inst_req   = 1'b0;
        inst_wr    = 1'b0;
        inst_size  = 2'd0;
        inst_addr  = 32'h0;
        inst_wdata = 32'h0;
        arready    = 1'b0;
        rid        = 4'd0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        rvalid     = 1'b0;
        step();
        step();
        #1;
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst_rdata", inst_rdata, 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_arsize", 32'(arsize), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Zero-wait slave, reset vector fetch.
        read_txn(32'hBFC0_0000, 2'd2, 0, 1'b0, 32'h3C1D_0001, 2'b00, 1'b0, 1'b0);
        // AR stalled for 5 cycles.
        read_txn(32'h8000_1000, 2'd2, 5, 1'b0, 32'hA5A5_0F0F, 2'b00, 1'b0, 1'b0);
        // Stray beat with foreign id precedes the real one.
        read_txn(32'h0000_0404, 2'd1, 0, 1'b1, 32'h1234_5678, 2'b00, 1'b0, 1'b0);
        // SLVERR sets sticky rd_err; a following OKAY read keeps it set.
        read_txn(32'h0000_0010, 2'd0, 0, 1'b0, 32'hCAFE_F00D, 2'b10, 1'b1, 1'b0);
        read_txn(32'h0000_0020, 2'd2, 2, 1'b0, 32'h0BAD_CAFE, 2'b00, 1'b1, 1'b0);
        // Back-to-back with inst_req held high throughout.
        read_txn(32'h1000_0000, 2'd2, 0, 1'b0, 32'h1111_2222, 2'b00, 1'b1, 1'b1);
        read_txn(32'h1000_0004, 2'd2, 1, 1'b0, 32'h3333_4444, 2'b00, 1'b1, 1'b1);
        inst_req = 1'b0;
        step();

        // Reset asserted while waiting in R.
        inst_req  = 1'b1;
        inst_addr = 32'h2000_0000;
        inst_size = 2'd2;
        step();
        inst_req = 1'b0;
        arready  = 1'b1;
        step();
        arready = 1'b0;
        #1;
        check("pre_rst_rready", 32'(rready), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_arvalid", 32'(arvalid), 32'd0);
        check("mid_rst_rready", 32'(rready), 32'd0);
        check("mid_rst_data_ok", 32'(inst_data_ok), 32'd0);
        check("mid_rst_rd_err", 32'(rd_err), 32'd0);
        check("mid_rst_rdata", inst_rdata, 32'd0);
        step();
        rst = 1'b0;
        step();
        read_txn(32'h2000_0040, 2'd2, 0, 1'b0, 32'h5566_7788, 2'b00, 1'b0, 1'b0);

        // Write requests are never accepted.
        inst_req  = 1'b1;
        inst_wr   = 1'b1;
        inst_addr = 32'h3000_0000;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("wr_addr_ok", 32'(inst_addr_ok), 32'd0);
            check("wr_arvalid", 32'(arvalid), 32'd0);
            step();
        end
        inst_req = 1'b0;
        inst_wr  = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
